// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state encoding and schedule sigma functions
// used by the round sequencer and the compression datapath.
package sha256_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_ROUND = 2'd2;
    localparam state_t ST_FINAL = 2'd3;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value, consumed by the compression datapath when iv_sel=1.
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_window.sv
// 16-word sliding message-schedule window; each shift retires W_t and
// appends W_{t+16} computed from the current window contents.
module sha256_msg_window
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] blk_data,
    output logic [31:0]  w_head
);

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_new;

    // win_q[0] holds W_t, so win_q[1], [9], [14] are W_{t+1}, W_{t+9}, W_{t+14}.
    assign w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = blk_data[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = w_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign w_head = win_q[0];

endmodule

// File: rtl/sha256_round_sched.sv
// SHA-256 compression sequencer: accepts a padded block, then drives load,
// ROUNDS round strobes with W_t/K_t, and the final hash-add/done pulse.
module sha256_round_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            blk_valid,
    output logic            blk_ready,
    input  logic [511:0]    blk_data,
    input  logic            blk_first,
    input  logic            pause,
    output logic            ld_work,
    output logic            iv_sel,
    output logic            rnd_en,
    output logic [5:0]      rnd_idx,
    output logic [WORD-1:0] w_t,
    output logic [WORD-1:0] k_t,
    output logic            hash_add,
    output logic            blk_done
);

    if (WORD != 32) begin : g_word_chk
        $error("sha256_round_sched: WORD must be 32");
    end
    if (ROUNDS < 16 || ROUNDS > 64) begin : g_rounds_chk
        $error("sha256_round_sched: ROUNDS must be 16..64");
    end

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic        first_q, first_d;
    logic        live_q;
    logic        accept;
    logic        in_round;
    logic [31:0] w_head;

    // live_q keeps blk_ready low until the first clock after reset release.
    assign blk_ready = live_q && (state_q == ST_IDLE);
    assign accept    = blk_valid && blk_ready;
    assign in_round  = (state_q == ST_ROUND);
    assign rnd_en    = in_round && !pause;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    first_d = blk_first;
                end
            end
            ST_LOAD: begin
                state_d = ST_ROUND;
                t_d     = '0;
            end
            ST_ROUND: begin
                if (rnd_en) begin
                    if (t_q == T_LAST) begin
                        state_d = ST_FINAL;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            first_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            first_q <= first_d;
            live_q  <= 1'b1;
        end
    end

    sha256_msg_window u_window (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (rnd_en),
        .blk_data (blk_data),
        .w_head   (w_head)
    );

    assign ld_work  = (state_q == ST_LOAD);
    assign iv_sel   = ld_work && first_q;
    assign hash_add = (state_q == ST_FINAL);
    assign blk_done = hash_add;
    assign rnd_idx  = in_round ? t_q : 6'd0;
    assign w_t      = in_round ? w_head : '0;
    assign k_t      = in_round ? K[t_q] : '0;

endmodule

// File: tb/tb_sha256_round_sched.sv
// Randomized self-checking bench for sha256_round_sched against a
// block-level reference model (full 64-word schedule, per-cycle phase).
module tb_sha256_round_sched;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_first = 1'b0;
    logic         pause = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready, ld_work, iv_sel, rnd_en, hash_add, blk_done;
    logic [5:0]   rnd_idx;
    logic [31:0]  w_t, k_t;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sha256_round_sched #(.ROUNDS(ROUNDS), .WORD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .pause     (pause),
        .ld_work   (ld_work),
        .iv_sel    (iv_sel),
        .rnd_en    (rnd_en),
        .rnd_idx   (rnd_idx),
        .w_t       (w_t),
        .k_t       (k_t),
        .hash_add  (hash_add),
        .blk_done  (blk_done)
    );

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase of the current block and its full 64-word schedule.
    typedef enum int {P_IDLE, P_LOAD, P_ROUND, P_FINAL} phase_t;
    phase_t      m_ph = P_IDLE;
    int          m_t = 0;
    bit          m_rdy = 1'b0;
    bit          m_first = 1'b0;
    logic [31:0] m_w [64];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph  = P_IDLE;
            m_t   = 0;
            m_rdy = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (m_rdy && blk_valid) begin
                    for (int i = 0; i < 16; i++) m_w[i] = blk_data[511 - 32*i -: 32];
                    for (int i = 16; i < 64; i++)
                        m_w[i] = s1(m_w[i-2]) + m_w[i-7] + s0(m_w[i-15]) + m_w[i-16];
                    m_first = blk_first;
                    m_ph    = P_LOAD;
                end
                P_LOAD: begin
                    m_ph = P_ROUND;
                    m_t  = 0;
                end
                P_ROUND: if (!pause) begin
                    if (m_t == ROUNDS - 1) m_ph = P_FINAL;
                    else m_t++;
                end
                default: m_ph = P_IDLE;
            endcase
            m_rdy = 1'b1;
        end
    end

    // Compare process plus event logs used by the directed checks.
    bit          cmp_on = 1'b0;
    int          cyc = 0;
    int          rnd_cnt = 0;
    int          acc_q[$];
    int          ld_q[$];
    int          done_q[$];
    logic        iv_q[$];
    logic [31:0] w_log[$];
    logic [31:0] k_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit in_rnd;
        if (cmp_on) begin
            in_rnd = (m_ph == P_ROUND);
            check("blk_ready", 32'(blk_ready), 32'(m_rdy && m_ph == P_IDLE));
            check("ld_work", 32'(ld_work), 32'(m_ph == P_LOAD));
            check("iv_sel", 32'(iv_sel), 32'(m_ph == P_LOAD && m_first));
            check("rnd_en", 32'(rnd_en), 32'(in_rnd && !pause));
            check("rnd_idx", 32'(rnd_idx), in_rnd ? 32'(m_t) : 32'd0);
            check("w_t", w_t, in_rnd ? m_w[m_t] : 32'd0);
            check("k_t", k_t, in_rnd ? K_REF[m_t] : 32'd0);
            check("hash_add", 32'(hash_add), 32'(m_ph == P_FINAL));
            check("blk_done", 32'(blk_done), 32'(m_ph == P_FINAL));
            check("strobe_excl", 32'($countones({ld_work, rnd_en, hash_add}) <= 1), 32'd1);
            if (blk_valid && blk_ready) acc_q.push_back(cyc + 1);
            if (ld_work) begin
                ld_q.push_back(cyc);
                iv_q.push_back(iv_sel);
                rnd_cnt = 0;
            end
            if (rnd_en) begin
                rnd_cnt++;
                w_log.push_back(w_t);
                k_log.push_back(k_t);
            end
            if (hash_add) begin
                check("rnd_per_block", 32'(rnd_cnt), 32'(ROUNDS));
                done_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [511:0] d, input logic f, input int pp);
        int na;
        na = acc_q.size();
        blk_data  = d;
        blk_first = f;
        blk_valid = 1'b1;
        for (int i = 0; i < 200 && acc_q.size() == na; i++) begin
            pause = ($urandom_range(0, 99) < pp);
            tick();
        end
        blk_valid = 1'b0;
        check("accept_seen", 32'(acc_q.size() > na), 32'd1);
    endtask

    task automatic wait_done(input int pp);
        int nd;
        nd = done_q.size();
        for (int i = 0; i < 400 && done_q.size() == nd; i++) begin
            pause = ($urandom_range(0, 99) < pp);
            tick();
        end
        pause = 1'b0;
        check("done_seen", 32'(done_q.size() > nd), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_strobes"}, 32'({blk_ready, ld_work, iv_sel, rnd_en, hash_add, blk_done}), 32'd0);
        check({name, "_rnd_idx"}, 32'(rnd_idx), 32'd0);
        check({name, "_w_t"}, w_t, 32'd0);
        check({name, "_k_t"}, k_t, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] d;
        logic [31:0]  ref_w [64];
        int           a, a1, n, diffs, p20, p63, nd;

        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;

        #2 rst = 1'b0;
        #1 cmp_on = 1'b1;
        #9 check_all_zero("reset");
        #11 rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(blk_ready), 32'd1);
        tick();

        // "abc" block, no pause
        w_log.delete(); k_log.delete();
        offer(abc, 1'b1, 0);
        a = acc_q[$];
        wait_done(0);
        check("abc_ld_cycle", 32'(ld_q[$] - a + 1), 32'd1);
        check("abc_iv_sel", 32'(iv_q[$]), 32'd1);
        check("abc_w_count", 32'(w_log.size()), 32'd64);
        for (int i = 0; i < 16; i++) check("abc_w_input", w_log[i], abc[511 - 32*i -: 32]);
        check("abc_w16", w_log[16], 32'h61626380);
        check("abc_w17", w_log[17], 32'h000F0000);
        check("abc_w18", w_log[18], 32'h7DA86405);
        check("abc_w19", w_log[19], 32'h600003C6);
        check("abc_k0", k_log[0], 32'h428A2F98);
        check("abc_k63", k_log[63], 32'hC67178F2);
        check("abc_done_cycle", 32'(done_q[$] - a + 1), 32'd66);
        for (int i = 0; i < 64; i++) ref_w[i] = w_log[i];

        // Same block, 5-cycle pause at t=20 and 1-cycle pause at t=63
        w_log.delete();
        offer(abc, 1'b1, 0);
        a = acc_q[$];
        nd = done_q.size();
        p20 = 0;
        p63 = 0;
        for (int i = 0; i < 300 && done_q.size() == nd; i++) begin
            if (rnd_idx == 6'd20 && p20 < 5) begin
                pause = 1'b1;
                p20++;
            end else if (rnd_idx == 6'd63 && p63 < 1) begin
                pause = 1'b1;
                p63++;
            end else begin
                pause = 1'b0;
            end
            tick();
        end
        pause = 1'b0;
        check("pause_done_seen", 32'(done_q.size() > nd), 32'd1);
        check("pause_done_cycle", 32'(done_q[$] - a + 1), 32'd72);
        check("pause_w_count", 32'(w_log.size()), 32'd64);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (w_log[i] !== ref_w[i]) diffs++;
        check("pause_w_same_seq", 32'(diffs), 32'd0);

        // Back-to-back: valid held high, data churns while busy
        n = acc_q.size();
        d = rand_blk();
        blk_data  = d;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        for (int i = 0; i < 200 && acc_q.size() == n; i++) tick();
        a1 = acc_q[$];
        blk_first = 1'b0;
        for (int i = 0; i < 200 && acc_q.size() < n + 2; i++) begin
            blk_data = rand_blk();
            tick();
        end
        blk_valid = 1'b0;
        check("b2b_two_accepts", 32'(acc_q.size()), 32'(n + 2));
        check("b2b_gap", 32'(acc_q[$] - a1), 32'd67);
        wait_done(0);
        check("b2b_iv_sel_first", 32'(iv_q[$-1]), 32'd1);
        check("b2b_iv_sel_second", 32'(iv_q[$]), 32'd0);

        // Random blocks with random pause (also outside ROUND)
        for (int b = 0; b < 5; b++) begin
            repeat ($urandom_range(0, 3)) begin
                pause = $urandom_range(0, 1) == 1;
                tick();
            end
            offer(rand_blk(), 1'($urandom_range(0, 1)), 30);
            wait_done(25);
        end

        // Reset asserted mid-block at t=30
        offer(rand_blk(), 1'b1, 0);
        for (int i = 0; i < 100 && rnd_idx != 6'd30; i++) tick();
        check("rst_reach_t30", 32'(rnd_idx), 32'd30);
        nd = done_q.size();
        #2 rst = 1'b0;
        #1 check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("rst_ready_before_edge", 32'(blk_ready), 32'd0);
        @(negedge clk);
        check("rst_ready_after_edge", 32'(blk_ready), 32'd1);
        repeat (70) tick();
        check("rst_no_done", 32'(done_q.size()), 32'(nd));

        offer(rand_blk(), 1'b0, 20);
        wait_done(20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
